// File: rtl/fetch_scheduler_pkg.sv
// rtl/fetch_scheduler_pkg.sv - shared compute-unit types for the fetch scheduler
package fetch_scheduler_pkg;

    localparam int unsigned ArbRoundRobin = 0;
    localparam int unsigned ArbGreedy     = 1;

    // Field widths are upper bounds; instances zero-extend into them.
    localparam int unsigned FetchPcMax      = 64;
    localparam int unsigned FetchMaskMax    = 64;
    localparam int unsigned FetchSubwarpMax = 8;
    localparam int unsigned FetchWidMax     = 8;

    typedef struct packed {
        logic [FetchPcMax-1:0]      pc;
        logic [FetchMaskMax-1:0]    act_mask;
        logic [FetchSubwarpMax-1:0] subwarp_id;
        logic [FetchWidMax-1:0]     wid;
    } fetch_req_t;

endpackage

// File: rtl/fetch_scheduler_credit_counter.sv
// rtl/fetch_scheduler_credit_counter.sv - per-warp instruction-buffer credit counter
module fetch_credit_counter #(
    parameter int unsigned IbDepth = 4,
    localparam int unsigned CreditWidth = $clog2(IbDepth + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   dec_i,
    input  logic                   pop_i,
    input  logic                   ret_i,
    output logic [CreditWidth-1:0] credit_o
);

    // Two spare bits: one for the +2 headroom, one to expose underflow as the MSB.
    localparam int unsigned SumWidth = CreditWidth + 2;

    logic [CreditWidth-1:0] count_q, count_d;
    logic [SumWidth-1:0]    sum;

    always_comb begin
        sum = SumWidth'(count_q) + SumWidth'(pop_i) + SumWidth'(ret_i) - SumWidth'(dec_i);
        if (sum[SumWidth-1]) begin
            count_d = '0;
        end else if (sum > SumWidth'(IbDepth)) begin
            count_d = CreditWidth'(IbDepth);
        end else begin
            count_d = sum[CreditWidth-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= CreditWidth'(IbDepth);
        end else begin
            count_q <= count_d;
        end
    end

    assign credit_o = count_q;

`ifndef SYNTHESIS
    credit_bounds_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !sum[SumWidth-1] && sum <= SumWidth'(IbDepth));
`endif

endmodule

// File: rtl/fetch_scheduler.sv
// rtl/fetch_scheduler.sv - credit-gated warp arbiter feeding a single-entry fetch request register
module fetch_scheduler
    import fetch_scheduler_pkg::*;
#(
    parameter int unsigned PcWidth   = 32,
    parameter int unsigned NumWarps  = 8,
    parameter int unsigned WarpWidth = 32,
    parameter int unsigned IbDepth   = 4,
    parameter int unsigned GreedyArb = ArbRoundRobin,
    localparam int unsigned WidWidth       = (NumWarps > 1) ? $clog2(NumWarps) : 1,
    localparam int unsigned SubwarpIdWidth = (WarpWidth > 1) ? $clog2(WarpWidth) : 1,
    localparam int unsigned CreditWidth    = $clog2(IbDepth + 1)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [NumWarps-1:0]                      warp_ready_i,
    input  logic [NumWarps-1:0][PcWidth-1:0]         warp_pc_i,
    input  logic [NumWarps-1:0][WarpWidth-1:0]       warp_act_mask_i,
    input  logic [NumWarps-1:0][SubwarpIdWidth-1:0]  warp_subwarp_id_i,
    output logic [NumWarps-1:0]                      warp_selected_o,
    input  logic [NumWarps-1:0]                      ib_pop_i,
    input  logic [NumWarps-1:0]                      flush_i,
    input  logic                                     ic_ready_i,
    output logic                                     fe_valid_o,
    output logic [PcWidth-1:0]                       fe_pc_o,
    output logic [WarpWidth-1:0]                     fe_act_mask_o,
    output logic [WidWidth-1:0]                      fe_warp_id_o,
    output logic [SubwarpIdWidth-1:0]                fe_subwarp_id_o,
    output logic [NumWarps-1:0][CreditWidth-1:0]     credits_o
);

    logic                                 valid_q, valid_d;
    fetch_req_t                           req_q, req_d;
    logic [WidWidth-1:0]                  ptr_q, ptr_d;
    logic [WidWidth-1:0]                  last_q, last_d;
    logic [NumWarps-1:0][CreditWidth-1:0] credit;
    logic [NumWarps-1:0]                  eligible;
    logic [NumWarps-1:0]                  grant_dec;
    logic [NumWarps-1:0]                  flush_ret;
    logic                                 can_load;
    logic                                 grant;
    logic                                 grant_found;
    logic [WidWidth-1:0]                  grant_idx;
    logic [WidWidth-1:0]                  held_wid;
    logic                                 held_flush;
    logic                                 unused_req_bits;

    function automatic logic [WidWidth-1:0] wrap_add(input logic [WidWidth-1:0] base,
                                                     input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NumWarps) begin
            sum = sum - NumWarps;
        end
        return WidWidth'(sum);
    endfunction

    always_comb begin
        eligible = '0;
        for (int w = 0; w < NumWarps; w++) begin
            eligible[w] = warp_ready_i[w] && (credit[w] != '0) && !flush_i[w];
        end
    end

    // Descending scan so the warp closest to the pointer is the last (winning) assignment.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = NumWarps; i > 0; i--) begin
            if (eligible[wrap_add(ptr_q, i - 1)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_add(ptr_q, i - 1);
            end
        end
        if (GreedyArb == ArbGreedy && eligible[last_q]) begin
            grant_found = 1'b1;
            grant_idx   = last_q;
        end
    end

    assign held_wid   = req_q.wid[WidWidth-1:0];
    assign can_load   = !valid_q || ic_ready_i;
    assign grant      = can_load && grant_found && !rst_i;
    assign held_flush = valid_q && !ic_ready_i && flush_i[held_wid];

    always_comb begin
        warp_selected_o = '0;
        grant_dec       = '0;
        flush_ret       = '0;
        for (int w = 0; w < NumWarps; w++) begin
            grant_dec[w] = grant && (grant_idx == WidWidth'(w));
            flush_ret[w] = held_flush && (held_wid == WidWidth'(w));
        end
        warp_selected_o = grant_dec;
    end

    always_comb begin
        valid_d = valid_q;
        req_d   = req_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        if (valid_q && (ic_ready_i || flush_i[held_wid])) begin
            valid_d = 1'b0;
        end
        if (grant) begin
            valid_d          = 1'b1;
            req_d.pc         = FetchPcMax'(warp_pc_i[grant_idx]);
            req_d.act_mask   = FetchMaskMax'(warp_act_mask_i[grant_idx]);
            req_d.subwarp_id = FetchSubwarpMax'(warp_subwarp_id_i[grant_idx]);
            req_d.wid        = FetchWidMax'(grant_idx);
            ptr_d            = wrap_add(grant_idx, 1);
            last_d           = grant_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            req_q   <= '0;
            ptr_q   <= '0;
            last_q  <= '0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
        end
    end

    for (genvar w = 0; w < NumWarps; w++) begin : g_credit
        fetch_credit_counter #(
            .IbDepth (IbDepth)
        ) u_credit (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .dec_i    (grant_dec[w]),
            .pop_i    (ib_pop_i[w]),
            .ret_i    (flush_ret[w]),
            .credit_o (credit[w])
        );
    end

    assign fe_valid_o      = valid_q;
    assign fe_pc_o         = req_q.pc[PcWidth-1:0];
    assign fe_act_mask_o   = req_q.act_mask[WarpWidth-1:0];
    assign fe_warp_id_o    = req_q.wid[WidWidth-1:0];
    assign fe_subwarp_id_o = req_q.subwarp_id[SubwarpIdWidth-1:0];
    assign credits_o       = credit;
    assign unused_req_bits = ^req_q;

`ifndef SYNTHESIS
    sel_onehot_a: assert property (@(posedge clk_i) $onehot0(warp_selected_o));
    mask_nonzero_a: assert property (@(posedge clk_i) disable iff (rst_i)
        fe_valid_o |-> (fe_act_mask_o != '0));
`endif

endmodule

// File: tb/tb_fetch_scheduler.sv
// tb/tb_fetch_scheduler.sv - scoreboard bench for round-robin and greedy fetch_scheduler instances
module tb_fetch_scheduler;

    localparam int NW = 8;
    localparam int PW = 32;
    localparam int WW = 32;
    localparam int SW = 5;
    localparam int IW = 3;
    localparam int CW = 3;

    typedef logic [IW+SW+WW+PW-1:0] req_vec_t;

    logic clk = 1'b0;
    logic rst;
    logic ic_ready;
    logic [NW-1:0] ready, pop, flush;
    logic [NW-1:0][PW-1:0] pc;
    logic [NW-1:0][WW-1:0] mask;
    logic [NW-1:0][SW-1:0] sub;

    logic [NW-1:0] sel_rr, sel_gr;
    logic valid_rr, valid_gr;
    logic [PW-1:0] pc_rr, pc_gr;
    logic [WW-1:0] mask_rr, mask_gr;
    logic [IW-1:0] wid_rr, wid_gr;
    logic [SW-1:0] sub_rr, sub_gr;
    logic [NW-1:0][CW-1:0] cred_rr, cred_gr;

    logic mon_gr = 1'b0;
    logic [NW-1:0] m_sel;
    logic m_valid;
    req_vec_t m_req;

    int n_cmp = 0;
    int n_bad = 0;
    logic [NW-1:0] exp_grant[$];
    req_vec_t exp_req[$];
    logic [NW-1:0] g_exp;
    req_vec_t r_exp;

    always #5 clk = ~clk;

    fetch_scheduler #(.GreedyArb(0)) dut_rr (
        .clk_i(clk), .rst_i(rst), .warp_ready_i(ready), .warp_pc_i(pc),
        .warp_act_mask_i(mask), .warp_subwarp_id_i(sub), .warp_selected_o(sel_rr),
        .ib_pop_i(pop), .flush_i(flush), .ic_ready_i(ic_ready), .fe_valid_o(valid_rr),
        .fe_pc_o(pc_rr), .fe_act_mask_o(mask_rr), .fe_warp_id_o(wid_rr),
        .fe_subwarp_id_o(sub_rr), .credits_o(cred_rr)
    );

    fetch_scheduler #(.GreedyArb(1)) dut_gr (
        .clk_i(clk), .rst_i(rst), .warp_ready_i(ready), .warp_pc_i(pc),
        .warp_act_mask_i(mask), .warp_subwarp_id_i(sub), .warp_selected_o(sel_gr),
        .ib_pop_i(pop), .flush_i(flush), .ic_ready_i(ic_ready), .fe_valid_o(valid_gr),
        .fe_pc_o(pc_gr), .fe_act_mask_o(mask_gr), .fe_warp_id_o(wid_gr),
        .fe_subwarp_id_o(sub_gr), .credits_o(cred_gr)
    );

    assign m_sel   = mon_gr ? sel_gr : sel_rr;
    assign m_valid = mon_gr ? valid_gr : valid_rr;
    assign m_req   = mon_gr ? {wid_gr, sub_gr, mask_gr, pc_gr} : {wid_rr, sub_rr, mask_rr, pc_rr};

    task automatic chk(input string name, input req_vec_t act, input req_vec_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input int w, input bit accepted);
        logic [NW-1:0] one;
        one = 1;
        exp_grant.push_back(one << w);
        if (accepted) begin
            exp_req.push_back({IW'(w), sub[w], mask[w], pc[w]});
        end
    endtask

    task automatic do_reset(input logic gr);
        rst = 1'b1; ready = '0; pop = '0; flush = '0; ic_ready = 1'b0;
        cyc();
        mon_gr = gr;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (m_sel != '0) begin
                n_cmp++;
                if (exp_grant.size() == 0) begin
                    n_bad++;
                    $display("FAIL grant_unexpected: got %b, required none", m_sel);
                end else begin
                    g_exp = exp_grant.pop_front();
                    if (m_sel !== g_exp) begin
                        n_bad++;
                        $display("FAIL grant_order: got %b, required %b", m_sel, g_exp);
                    end
                end
            end
            if (m_valid && ic_ready) begin
                n_cmp++;
                if (exp_req.size() == 0) begin
                    n_bad++;
                    $display("FAIL req_unexpected: got %0h, required none", m_req);
                end else begin
                    r_exp = exp_req.pop_front();
                    if (m_req !== r_exp) begin
                        n_bad++;
                        $display("FAIL req_payload: got %0h, required %0h", m_req, r_exp);
                    end
                end
            end
        end
    end

    initial begin
        for (int w = 0; w < NW; w++) begin
            pc[w]   = 32'h1000 + 32'(w * 16);
            mask[w] = 32'hF0F0_0000 | 32'(w + 1);
            sub[w]  = SW'(w * 3);
        end
        rst = 1'b1; ready = '1; pop = '0; flush = '0; ic_ready = 1'b1;

        // reset state, with every warp requesting
        @(negedge clk);
        chk("rst_sel", req_vec_t'(sel_rr), '0);
        chk("rst_valid", req_vec_t'(valid_rr), '0);
        chk("rst_credits", req_vec_t'(cred_rr), req_vec_t'({NW{3'd4}}));
        chk("rst_pc", req_vec_t'(pc_rr), '0);
        chk("rst_mask", req_vec_t'(mask_rr), '0);
        chk("rst_ids", req_vec_t'({wid_rr, sub_rr}), '0);

        // round-robin sweep 0..7,0
        do_reset(1'b0);
        ready = '1; ic_ready = 1'b1;
        for (int w = 0; w < NW; w++) expect_grant(w, 1'b1);
        expect_grant(0, 1'b1);
        cyc();
        @(negedge clk);
        chk("rr_credit0_first", req_vec_t'(cred_rr[0]), 3);
        repeat (8) cyc();
        ready = '0;
        @(negedge clk);
        chk("rr_credits_end", req_vec_t'(cred_rr), req_vec_t'({{7{3'd3}}, 3'd2}));
        cyc();

        // credit exhaustion on warp 2
        do_reset(1'b0);
        ready = 8'h04; ic_ready = 1'b1;
        repeat (4) expect_grant(2, 1'b1);
        repeat (6) cyc();
        @(negedge clk);
        chk("exh_credit2_zero", req_vec_t'(cred_rr[2]), 0);
        chk("exh_no_grant", req_vec_t'(sel_rr), 0);
        cyc();
        pop = 8'h04;
        expect_grant(2, 1'b1);
        @(negedge clk);
        chk("exh_pop_cycle_no_grant", req_vec_t'(sel_rr), 0);
        cyc();
        pop = '0;
        @(negedge clk);
        chk("exh_regrant", req_vec_t'(sel_rr), 8'h04);
        repeat (3) cyc();
        @(negedge clk);
        chk("exh_credit2_again", req_vec_t'(cred_rr[2]), 0);
        ready = '0;
        cyc();

        // backpressure holding warp 5 at 0x100
        do_reset(1'b0);
        pc[5] = 32'h100;
        ready = 8'h20; ic_ready = 1'b0;
        expect_grant(5, 1'b1);
        cyc();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", req_vec_t'(valid_rr), 1);
            chk("bp_pc", req_vec_t'(pc_rr), 32'h100);
            chk("bp_wid", req_vec_t'(wid_rr), 5);
            chk("bp_no_grant", req_vec_t'(sel_rr), 0);
            cyc();
        end
        ic_ready = 1'b1;
        expect_grant(5, 1'b1);
        @(negedge clk);
        chk("bp_accept_and_grant", req_vec_t'(sel_rr), 8'h20);
        cyc();
        ready = '0;
        cyc();
        pc[5] = 32'h1050;

        // flush of a held entry, then flush coinciding with accept
        do_reset(1'b0);
        ready = 8'h08; ic_ready = 1'b0;
        expect_grant(3, 1'b1);
        cyc();
        ic_ready = 1'b1;
        expect_grant(3, 1'b0);
        cyc();
        ready = '0; ic_ready = 1'b0; flush = 8'h08;
        @(negedge clk);
        chk("fl_credit_before", req_vec_t'(cred_rr[3]), 2);
        chk("fl_valid_before", req_vec_t'(valid_rr), 1);
        cyc();
        flush = '0;
        @(negedge clk);
        chk("fl_valid_cleared", req_vec_t'(valid_rr), 0);
        chk("fl_credit_returned", req_vec_t'(cred_rr[3]), 3);
        cyc();
        ready = 8'h08; ic_ready = 1'b0;
        expect_grant(3, 1'b1);
        cyc();
        ready = '0; flush = 8'h08; ic_ready = 1'b1;
        cyc();
        flush = '0;
        @(negedge clk);
        chk("fl_acc_valid", req_vec_t'(valid_rr), 0);
        chk("fl_acc_credit", req_vec_t'(cred_rr[3]), 2);
        cyc();

        // greedy: warp 1 four times, then warp 4
        do_reset(1'b1);
        ready = 8'h12; ic_ready = 1'b1;
        repeat (4) expect_grant(1, 1'b1);
        repeat (4) expect_grant(4, 1'b1);
        repeat (10) cyc();
        @(negedge clk);
        chk("gr_credit1", req_vec_t'(cred_gr[1]), 0);
        chk("gr_credit4", req_vec_t'(cred_gr[4]), 0);
        ready = '0;
        cyc();

        // grant+pop same cycle, then reset with a request held
        do_reset(1'b0);
        ready = 8'h01; ic_ready = 1'b1;
        expect_grant(0, 1'b1);
        cyc();
        pop = 8'h01;
        expect_grant(0, 1'b1);
        cyc();
        pop = '0; ready = '0;
        @(negedge clk);
        chk("sim_credit0", req_vec_t'(cred_rr[0]), 3);
        cyc();
        ready = 8'h01; ic_ready = 1'b0;
        expect_grant(0, 1'b0);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_valid_held", req_vec_t'(valid_rr), 1);
        chk("mid_rst_no_sel", req_vec_t'(sel_rr), 0);
        cyc();
        rst = 1'b0; ready = '0;
        @(negedge clk);
        chk("mid_valid_dropped", req_vec_t'(valid_rr), 0);
        chk("mid_credits", req_vec_t'(cred_rr), req_vec_t'({NW{3'd4}}));
        cyc();

        @(negedge clk);
        chk("grant_queue_drained", req_vec_t'(exp_grant.size()), 0);
        chk("req_queue_drained", req_vec_t'(exp_req.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
